// File: rtl/tx_hs_pkg.sv
// Shared types and sizing helpers for the D-PHY HS transmit serializer.
package tx_hs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    DATA  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hB8;

  // Counter width able to hold n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_ddr_out_cell.sv
// Dual-edge output cell: even bit drives the high phase, odd bit the low phase.
// Odd bit is staged at posedge and handed to the negedge register half a cycle later.
module tx_ddr_out_cell (
  input  logic clk,
  input  logic rst,
  input  logic even_bit,
  input  logic odd_bit,
  input  logic en,
  output logic line
);

  logic pos_q;
  logic odd_q;
  logic neg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= 1'b0;
      odd_q <= 1'b0;
    end else begin
      pos_q <= en & even_bit;
      odd_q <= en & odd_bit;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= odd_q;
    end
  end

  assign line = clk ? pos_q : neg_q;

endmodule

// File: rtl/tx_hs_ddr_serializer.sv
// Multi-lane HS serializer: sync word, gapless payload words, then inverted-last-bit trail.
// Request at posedge N puts sync bit 0 on the line in the high phase after posedge N+1.
module tx_hs_ddr_serializer
  import tx_hs_pkg::*;
#(
  parameter int                LANES        = 1,
  parameter int                WORD_W       = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD    = WORD_W'(SYNC_WORD_DEFAULT),
  parameter int                TRAIL_CYCLES = 4
) (
  input  logic                    TxDDRClkHS,
  input  logic                    TxRst,
  input  logic                    hs_request,
  input  logic [LANES-1:0]        lane_en,
  input  logic [LANES*WORD_W-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [LANES-1:0]        MuxOut,
  output logic                    hs_active,
  output logic                    burst_done,
  output logic                    underrun
);

  localparam int CNT_W = cnt_width(WORD_W / 2);
  localparam int TRL_W = cnt_width(TRAIL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_W / 2 - 1);
  localparam logic [TRL_W-1:0] TRL_LOAD = TRL_W'(TRAIL_CYCLES - 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [TRL_W-1:0]               tcnt;
  logic [LANES-1:0][WORD_W-1:0]   sh_q;
  logic [LANES-1:0]               last_bit;
  logic [LANES-1:0]               lane_mask;
  logic [LANES-1:0]               even_bit;
  logic [LANES-1:0]               odd_bit;
  logic [LANES-1:0]               cell_en;

  assign tx_ready = ((state == SYNC) || (state == DATA)) && (cnt == '0);

  always_ff @(posedge TxDDRClkHS) begin
    if (TxRst) begin
      state      <= IDLE;
      cnt        <= '0;
      tcnt       <= '0;
      sh_q       <= '0;
      last_bit   <= '0;
      lane_mask  <= '0;
      hs_active  <= 1'b0;
      burst_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        IDLE: begin
          if (hs_request && (lane_en != '0)) begin
            state     <= SYNC;
            lane_mask <= lane_en;
            sh_q      <= {LANES{SYNC_WORD}};
            cnt       <= CNT_LOAD;
            underrun  <= 1'b0;
            hs_active <= 1'b1;
          end
        end
        SYNC, DATA: begin
          for (int i = 0; i < LANES; i++) begin
            last_bit[i] <= sh_q[i][1];
          end
          if (cnt != '0) begin
            for (int i = 0; i < LANES; i++) begin
              sh_q[i] <= sh_q[i] >> 2;
            end
            cnt <= cnt - 1'b1;
          end else if (tx_valid) begin
            // Reload at the word boundary so the next pair follows without a gap.
            sh_q  <= tx_data;
            cnt   <= CNT_LOAD;
            state <= DATA;
          end else begin
            state <= TRAIL;
            tcnt  <= TRL_LOAD;
            if (hs_request) begin
              underrun <= 1'b1;
            end
          end
        end
        TRAIL: begin
          if (tcnt == '0) begin
            state      <= IDLE;
            burst_done <= 1'b1;
            hs_active  <= 1'b0;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    even_bit = '0;
    odd_bit  = '0;
    cell_en  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (state == TRAIL) begin
        even_bit[i] = ~last_bit[i];
        odd_bit[i]  = ~last_bit[i];
      end else begin
        even_bit[i] = sh_q[i][0];
        odd_bit[i]  = sh_q[i][1];
      end
      cell_en[i] = lane_mask[i] && (state != IDLE);
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    tx_ddr_out_cell u_cell (
      .clk      (TxDDRClkHS),
      .rst      (TxRst),
      .even_bit (even_bit[g]),
      .odd_bit  (odd_bit[g]),
      .en       (cell_en[g]),
      .line     (MuxOut[g])
    );
  end

endmodule

// File: tb/tb_tx_hs_ddr_serializer.sv
// Scoreboard bench: stimulus queues per-cycle expected line/status, a monitor pops and compares.
module tb_tx_hs_ddr_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs_request;
  logic [1:0]  lane_en;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  mux;
  logic        hs_active;
  logic        burst_done;
  logic        underrun;

  tx_hs_ddr_serializer #(
    .LANES        (2),
    .WORD_W       (8),
    .SYNC_WORD    (8'hB8),
    .TRAIL_CYCLES (4)
  ) dut (
    .TxDDRClkHS (clk),
    .TxRst      (rst),
    .hs_request (hs_request),
    .lane_en    (lane_en),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .MuxOut     (mux),
    .hs_active  (hs_active),
    .burst_done (burst_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] hi;
    logic [1:0] lo;
    logic       act;
    logic       done;
    logic       rdy;
    logic       unr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] wq[0:3];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  int          act_cnt = 0;
  int          b_hs, b_dn, b_act;
  logic        cur_unr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, got, want);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s at cycle %0d: wait bound expired", nm, cyc);
  endtask

  // Bit idx of a lane's HS stream: sync word then the queued words, LSB-first.
  function automatic logic sbit(input int lane, input int idx);
    logic [7:0] s;
    logic [15:0] w;
    s = 8'hB8;
    if (idx < 8) return s[idx];
    w = wq[(idx - 8) / 8];
    return w[lane * 8 + (idx % 8)];
  endfunction

  task automatic push_idle(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      e.unr = cur_unr;
      exp_q.push_back(e);
    end
  endtask

  // Entry 0 is the request cycle, entry j+1 is j cycles after SYNC entry.
  task automatic push_burst(input logic [1:0] mask, input int nw, input logic unr_end, input int cut);
    int   p_tot;
    int   last;
    int   jmax;
    exp_t e;
    p_tot = 4 * (1 + nw);
    last  = 8 * (1 + nw) - 1;
    jmax  = (cut >= 0) ? cut + 4 : p_tot + 4;
    push_idle(1);
    for (int j = 0; j <= jmax; j++) begin
      e = '0;
      if (cut < 0 || j < cut) begin
        e.act  = (j < p_tot + 4);
        e.rdy  = (j < p_tot) && (j % 4 == 3);
        e.done = (j == p_tot + 4);
        e.unr  = (j < p_tot) ? 1'b0 : unr_end;
        for (int l = 0; l < 2; l++) begin
          if (j >= 1 && j <= p_tot) begin
            e.hi[l] = mask[l] & sbit(l, 2 * (j - 1));
            e.lo[l] = mask[l] & sbit(l, 2 * (j - 1) + 1);
          end else if (j > p_tot && j <= p_tot + 4) begin
            e.hi[l] = mask[l] & ~sbit(l, last);
            e.lo[l] = e.hi[l];
          end
        end
      end
      exp_q.push_back(e);
    end
    cur_unr = (cut >= 0) ? 1'b0 : unr_end;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      tick();
      b++;
    end
    if (exp_q.size() != 0) fail("drain");
  endtask

  task automatic send_word(input int idx);
    logic r;
    int   b;
    tx_data  = wq[idx];
    tx_valid = 1'b1;
    b = 0;
    do begin
      r = tx_ready;
      tick();
      b++;
    end while (!r && b < 20);
    if (!r) fail("handshake");
    tx_valid = 1'b0;
  endtask

  task automatic monitor();
    logic [1:0] hi;
    logic [1:0] lo;
    logic       act, dn, rd, un;
    exp_t       e;
    forever begin
      @(posedge clk);
      #3;
      cyc++;
      hi  = mux;
      act = hs_active;
      dn  = burst_done;
      rd  = tx_ready;
      un  = underrun;
      if (act === 1'b1) act_cnt++;
      if (dn === 1'b1) done_cnt++;
      @(negedge clk);
      if (tx_valid && tx_ready === 1'b1) hs_cnt++;
      #3;
      lo = mux;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mux_high_phase", 32'(hi), 32'(e.hi));
        chk("mux_low_phase", 32'(lo), 32'(e.lo));
        chk("hs_active", 32'(act), 32'(e.act));
        chk("burst_done", 32'(dn), 32'(e.done));
        chk("tx_ready", 32'(rd), 32'(e.rdy));
        chk("underrun", 32'(un), 32'(e.unr));
      end
    end
  endtask

  task automatic snap();
    b_hs  = hs_cnt;
    b_dn  = done_cnt;
    b_act = act_cnt;
  endtask

  initial begin
    rst        = 1'b1;
    hs_request = 1'b0;
    tx_valid   = 1'b0;
    lane_en    = 2'b00;
    tx_data    = '0;
    fork
      monitor();
    join_none
    tick();
    tick();
    push_idle(3);
    tick();
    rst = 1'b0;
    drain();

    // Single word, both lanes: lane0 C3 trails 0s, lane1 5A trails 1s.
    lane_en = 2'b11;
    wq[0] = 16'h5AC3;
    snap();
    push_burst(2'b11, 1, 1'b0, -1);
    hs_request = 1'b1;
    tick();
    hs_request = 1'b0;
    send_word(0);
    drain();
    chk("t1_handshakes", hs_cnt - b_hs, 1);
    chk("t1_done_pulses", done_cnt - b_dn, 1);
    chk("t1_active_cycles", act_cnt - b_act, 12);

    // Three back-to-back words.
    wq[0] = 16'hA55A;
    wq[1] = 16'h0FF0;
    wq[2] = 16'h8001;
    snap();
    push_burst(2'b11, 3, 1'b0, -1);
    hs_request = 1'b1;
    tick();
    hs_request = 1'b0;
    for (int w = 0; w < 3; w++) send_word(w);
    drain();
    chk("t2_handshakes", hs_cnt - b_hs, 3);
    chk("t2_done_pulses", done_cnt - b_dn, 1);
    chk("t2_active_cycles", act_cnt - b_act, 20);

    // Request held, no data at end of sync: underrun.
    snap();
    push_burst(2'b11, 0, 1'b1, -1);
    hs_request = 1'b1;
    repeat (6) tick();
    hs_request = 1'b0;
    drain();
    chk("t3_underrun_sticky", 32'(underrun), 1);
    chk("t3_done_pulses", done_cnt - b_dn, 1);
    chk("t3_handshakes", hs_cnt - b_hs, 0);

    // Lane 1 disabled at burst start; enabling it mid-burst has no effect.
    lane_en = 2'b01;
    wq[0] = 16'h3C96;
    wq[1] = 16'hFF5A;
    snap();
    push_burst(2'b01, 2, 1'b0, -1);
    hs_request = 1'b1;
    tick();
    hs_request = 1'b0;
    send_word(0);
    lane_en = 2'b11;
    send_word(1);
    drain();
    chk("t4_handshakes", hs_cnt - b_hs, 2);
    chk("t4_done_pulses", done_cnt - b_dn, 1);

    // Reset during the second DATA cycle aborts without trail.
    wq[0] = 16'hE71B;
    snap();
    push_burst(2'b11, 1, 1'b0, 6);
    hs_request = 1'b1;
    tick();
    hs_request = 1'b0;
    send_word(0);
    tick();
    @(negedge clk);
    #1;
    rst = 1'b1;
    tick();
    @(negedge clk);
    #1;
    rst = 1'b0;
    drain();
    chk("t5_done_pulses", done_cnt - b_dn, 0);
    chk("t5_active_cycles", act_cnt - b_act, 6);

    // Request with no lanes enabled is ignored.
    lane_en = 2'b00;
    snap();
    push_idle(11);
    hs_request = 1'b1;
    repeat (10) tick();
    hs_request = 1'b0;
    drain();
    chk("t6_active_cycles", act_cnt - b_act, 0);
    chk("t6_done_pulses", done_cnt - b_dn, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
